// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 byte receiver.
//   ps2_rx_state_t : receiver FSM states
//   PS2_DATA_BITS  : data bits per frame
//   PS2_FRAME_BITS : total bits per frame (start + data + parity + stop)
//   odd_parity_ok  : true when data plus parity bit holds an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic                     p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_byte_if.sv
// ps2_rx_byte_if: PS/2 line pair plus the received-byte status bundle.
//   ps2_clk, ps2_data : raw PS/2 lines (device side drives)
//   out_byte          : last good byte
//   out_valid         : one-cycle strobe, out_byte valid
//   parity_err        : one-cycle strobe, frame had bad parity
//   frame_err         : one-cycle strobe, bad stop bit or timeout
//   busy              : receiver is mid-frame
// master = device/consumer side, slave = receiver.
interface ps2_rx_byte_if;
  import ps2_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic [PS2_DATA_BITS-1:0] out_byte;
  logic                     out_valid;
  logic                     parity_err;
  logic                     frame_err;
  logic                     busy;

  modport master (
    output ps2_clk, ps2_data,
    input  out_byte, out_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output out_byte, out_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: synchronises the raw PS/2 lines into the clk domain,
// debounces the PS/2 clock and emits a one-cycle pulse on each filtered fall.
//   clk, areset_n : system clock, async active-low reset
//   ps2_clk_i     : raw PS/2 clock
//   ps2_data_i    : raw PS/2 data
//   fall_o        : one-cycle pulse on each 1->0 of the filtered clock
//   data_o        : synchronised PS/2 data
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic areset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       fclk_q, fclk_d;
  logic       fall_q, fall_d;
  logic [3:0] cnt_q,  cnt_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      fclk_q      <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      fclk_q      <= fclk_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
    end
  end

  // The run counter restarts whenever the synchronised clock agrees with
  // fclk, so any excursion shorter than FILTER_LEN samples is discarded.
  always_comb begin
    fclk_d = fclk_q;
    fall_d = 1'b0;
    cnt_d  = 4'd0;
    if (clk_sync_q[1] != fclk_q) begin
      if (cnt_q == CNT_LAST) begin
        fclk_d = clk_sync_q[1];
        fall_d = fclk_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign fall_o = fall_q;
  assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: deserialises 11-bit PS/2 frames (start, 8 data LSB first,
// odd parity, stop) and reports each frame as a one-cycle status strobe.
//   clk, areset_n : system clock, async active-low reset
//   bus (slave)   : ps2_clk/ps2_data in; out_byte, out_valid, parity_err,
//                   frame_err, busy out
// FILTER_LEN sets the PS/2 clock glitch filter length, TIMEOUT the number of
// cycles after the last filtered fall at which a stalled frame is aborted.
module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 10000
) (
  input  logic         clk,
  input  logic         areset_n,
  ps2_rx_byte_if.slave bus
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  // The counter reads (cycles since last fall - 1); firing at TIMEOUT-2
  // lands the registered frame_err exactly TIMEOUT cycles after that fall.
  localparam logic [TW-1:0]  TMO_FIRE = TW'(TIMEOUT - 2);
  localparam logic [2:0]     LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic fall;
  logic data;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk        (clk),
    .areset_n   (areset_n),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .fall_o     (fall),
    .data_o     (data)
  );

  ps2_rx_state_t            state_q,      state_d;
  logic [PS2_DATA_BITS-1:0] shreg_q,      shreg_d;
  logic [2:0]               bit_cnt_q,    bit_cnt_d;
  logic                     par_q,        par_d;
  logic [TW-1:0]            tmo_q,        tmo_d;
  logic [PS2_DATA_BITS-1:0] out_byte_q,   out_byte_d;
  logic                     out_valid_q,  out_valid_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q,  frame_err_d;
  logic                     tmo_hit;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= 3'd0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
    tmo_hit      = (state_q != IDLE) && (tmo_q == TMO_FIRE);

    // A timeout beats a coincident fall: the edge is dropped.
    if (tmo_hit) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      shreg_d     = '0;
      bit_cnt_d   = 3'd0;
      tmo_d       = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d   = {data, shreg_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data) begin
            frame_err_d = 1'b1;
          end else if (odd_parity_ok(shreg_q, par_q)) begin
            out_byte_d  = shreg_q;
            out_valid_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.out_byte   = out_byte_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_byte.sv
// tb_ps2_rx_byte: scoreboard bench for ps2_rx_byte. Frames are built from a
// byte, a parity bit and a stop bit; the expected outcome and the cycle it
// must appear in are pushed when the deciding edge is driven, and a monitor
// pops and compares whenever any status strobe is seen.
module tb_ps2_rx_byte;
  import ps2_pkg::*;

  localparam int FL  = 4;
  localparam int TMO = 300;

  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRAME = 2;

  logic clk      = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  ps2_rx_byte_if bus();

  ps2_rx_byte #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_last = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0);
  endfunction

  // Drive the first nbits bits of a frame; bit period is 2*half cycles.
  task automatic send(input logic [7:0] b, input logic par, input logic stop,
                      input int half, input int nbits, input bit tmo_exp);
    logic [PS2_FRAME_BITS-1:0] bits;
    exp_t e;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 bus.ps2_data = bits[i];
      repeat (half) @(posedge clk);
      #1 bus.ps2_clk = 1'b0;
      if (i == PS2_FRAME_BITS - 1) begin
        if (!stop) e.kind = K_FRAME;
        else if ($countones({b, par}) % 2 == 1) begin
          e.kind     = K_VALID;
          model_last = b;
        end else e.kind = K_PAR;
        e.b  = model_last;
        e.at = cyc + 3 + FL;
        sb.push_back(e);
      end else if (i == nbits - 1 && tmo_exp) begin
        e.kind = K_FRAME;
        e.b    = model_last;
        e.at   = cyc + 2 + FL + TMO;
        sb.push_back(e);
      end
      repeat (half) @(posedge clk);
      #1 bus.ps2_clk = 1'b1;
    end
    @(posedge clk); #1 bus.ps2_data = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_byte"},   bus.out_byte,   0);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_parity_err"}, bus.parity_err, 0);
    check({tag, "_frame_err"},  bus.frame_err,  0);
    check({tag, "_busy"},       bus.busy,       0);
  endtask

  // Monitor
  int   mon_s;
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (areset_n) begin
      mon_s = int'(bus.out_valid) + int'(bus.parity_err) + int'(bus.frame_err);
      if (mon_s > 0) begin
        check("strobe_onehot", mon_s, 1);
        check("busy_at_strobe", bus.busy, 0);
        mon_kind = bus.out_valid ? K_VALID : (bus.parity_err ? K_PAR : K_FRAME);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", mon_kind, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_kind", mon_kind, mon_e.kind);
          check("strobe_cycle", cyc, mon_e.at);
          check("out_byte", bus.out_byte, mon_e.b);
        end
      end
    end
  end

  bit busy_seen;

  initial begin
    logic [7:0] rb;
    logic       rp, rs;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 areset_n = 1'b1;
    repeat (10) @(posedge clk);

    // Good byte, parity error, stop-bit error, then a clean retry.
    send(8'h08, good_par(8'h08), 1'b1, 100, 11, 0);
    @(negedge clk); check("busy_after_good", bus.busy, 0);
    send(8'h5A, 1'b0, 1'b1, 100, 11, 0);
    send(8'h3C, good_par(8'h3C), 1'b0, 100, 11, 0);
    send(8'h3C, good_par(8'h3C), 1'b1, 100, 11, 0);

    // Short glitch on the clock while idle must be ignored.
    repeat (20) @(posedge clk);
    #1 bus.ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.ps2_clk = 1'b1;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    check("glitch_busy", busy_seen, 0);

    // Stalled frame: start plus 4 data bits, then the clock stays high.
    send(8'hA5, 1'b0, 1'b1, 80, 5, 1);
    @(negedge clk); check("busy_midframe", bus.busy, 1);
    repeat (TMO + 40) @(posedge clk);
    @(negedge clk); check("busy_after_timeout", bus.busy, 0);
    send(8'hFF, 1'b1, 1'b1, 100, 11, 0);

    // Back-to-back frames, then reset in the middle of a fourth.
    send(8'h08, good_par(8'h08), 1'b1, 100, 11, 0);
    send(8'h12, good_par(8'h12), 1'b1, 100, 11, 0);
    send(8'h34, good_par(8'h34), 1'b1, 100, 11, 0);
    send(8'h77, good_par(8'h77), 1'b1, 100, 4, 0);
    @(posedge clk); #1 areset_n = 1'b0;
    model_last = 8'h00;
    #1 check_reset_vals("midreset");
    repeat (3) @(posedge clk);
    #1 areset_n = 1'b1;
    repeat (10) @(posedge clk);
    send(8'h08, good_par(8'h08), 1'b1, 100, 11, 0);

    // Randomised frames with occasional parity and stop-bit faults.
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      rp = good_par(rb) ^ ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 4) != 0);
      send(rb, rp, rs, $urandom_range(20, 120), 11, 0);
      repeat ($urandom_range(1, 30)) @(posedge clk);
    end

    repeat (50) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_byte.md
# ps2_rx_byte

Serial front end for the PS/2 mouse path. Receives the device-driven `ps2_clk`/`ps2_data` line pair and deserialises each 11-bit PS/2 frame: start bit, 8 data bits LSB first, odd parity bit, stop bit. Delivers each good byte as a one-cycle strobe with data to the downstream packet-boundary FSM, which groups bytes into 3-byte mouse messages. Flags bad frames separately and never forwards them.

## Interface
- `FILTER_LEN`, default 4: consecutive `clk` samples the synchronised `ps2_clk` must hold a new level before the filtered clock changes. Range 1..15.
- `TIMEOUT`, default 10000: `clk` cycles without a filtered falling edge, while mid-frame, before the frame is aborted. Must be ≥ 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `areset_n` input 1: asynchronous, active-low reset. The polarity and synchronicity are fixed.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`, idles high.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clk`, idles high.
- `out_byte` output 8: last good byte; holds its value between strobes.
- `out_valid` output 1: one-cycle strobe; `out_byte` is valid in that cycle.
- `parity_err` output 1: one-cycle strobe when a frame is complete but its parity is wrong.
- `frame_err` output 1: one-cycle strobe on a stop bit of 0 or a timeout.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Front end:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. Both flops reset to 1.
  - A filtered clock `fclk` (reset 1) takes the synchronised clock's new level after that level has been stable for `FILTER_LEN` consecutive cycles.
  - `fall` pulses for one cycle on each 1→0 transition of `fclk`.
  - Every sample of data is taken from the synchronised `ps2_data` in a cycle where `fall` = 1.
- States: IDLE, DATA, PARITY, STOP. Reset state is IDLE.
- Transitions, each evaluated only when `fall` = 1 unless stated otherwise:
  - IDLE: if data = 0, go to DATA and clear `bit_cnt`. If data = 1, stay in IDLE; this is a spurious edge and no flag is raised.
  - DATA: shift the data bit into `shreg[7]` with a right shift, then increment `bit_cnt`. After the 8th bit (`bit_cnt` = 7 before the increment), go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP, with data = 1 and (XOR of `shreg` and the parity bit) = 1: load `out_byte` with `shreg`, pulse `out_valid`, go to IDLE.
  - STOP, with data = 1 and odd parity failed: pulse `parity_err`, leave `out_byte` unchanged, go to IDLE.
  - STOP, with data = 0: pulse `frame_err`; this takes precedence over the parity check. Go to IDLE.
- Timeout:
  - The timeout counter clears on reset, in IDLE, and on every `fall`.
  - Outside IDLE it increments by 1 each cycle.
  - When it reaches `TIMEOUT`: pulse `frame_err`, go to IDLE, and clear `shreg` and `bit_cnt`.
  - If `fall` occurs in the same cycle, the timeout wins and that edge is ignored.
- At most one of `out_valid`, `parity_err`, `frame_err` is high in any cycle.
- Reset mid-frame: all state, outputs, synchronisers and `fclk` return to their reset values immediately. Reception restarts cleanly at the next start bit.

## Timing
- Reset values:
  - `out_byte` = 0x00
  - `out_valid`, `parity_err`, `frame_err`, `busy` = 0
  - `fclk` = 1
  - timeout counter = 0
- Edge latency: a raw `ps2_clk` fall that is held low produces `fall` 2 + `FILTER_LEN` cycles later.
- Strobe latency: `out_valid`, `parity_err` or `frame_err` is registered, and asserts the cycle after the `fall` that samples the stop bit.
- `busy` is high starting the cycle after the start-bit `fall`. It drops in the same cycle the status strobe asserts.
- Strobes are exactly one cycle wide, with no backpressure. The downstream FSM advances only on `out_valid`.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.

## Structure
- Package `ps2_pkg` holds:
  - enum `ps2_rx_state_t` {IDLE, DATA, PARITY, STOP}
  - localparams `PS2_DATA_BITS` = 8 and `PS2_FRAME_BITS` = 11
- Sub-module `ps2_sync_filter`: both synchronisers, the `FILTER_LEN` glitch filter and the `fall` edge detector. Its outputs are `fall` and the synchronised data.
- Top level: the state machine, `shreg`, `bit_cnt` (3 bits), the timeout counter of width $clog2(`TIMEOUT`+1), and the output registers.

## Test plan
- Valid frame for 0x08 (parity bit 0, stop 1), bit period 200 clk → `out_byte` = 0x08, `out_valid` high one cycle, both error flags 0, `busy` low afterwards.
- Frame for 0x5A sent with parity bit 0 (should be 1) → `parity_err` one cycle, `out_valid` never asserts, `out_byte` holds its prior value.
- Frame for 0x3C sent with stop bit 0 → `frame_err` one cycle, no `out_valid`. A following valid 0x3C frame → `out_valid`, `out_byte` = 0x3C.
- 2-cycle low glitch on `ps2_clk` while in IDLE, with `FILTER_LEN` = 4 → no state change, `busy` stays 0, no strobes.
- Start bit plus 4 data bits, then `ps2_clk` held high → `frame_err` exactly `TIMEOUT` cycles after the last `fall`. The next frame, 0xFF (parity bit 1), yields `out_byte` = 0xFF.
- Back-to-back frames 0x08, 0x12, 0x34 (stop bits 1), then `areset_n` pulsed low mid-way through a 4th frame → three `out_valid` pulses in order, then all outputs at reset values. A subsequent 0x08 frame is received correctly.
